// File: rtl/regfile_scoreboard_if.sv
// ----------------------------------------------------------------------------
// regfile_scoreboard_if
//   Bundle of the register-file / scoreboard bus shared by decode (read ports,
//   issue) and write-back (write port).
//
//   Parameters:
//     DATA_W : register width
//     ADDR_W : register index width
//
//   Signals (direction seen from the register file, modport "slave"):
//     rs_addr, rt_addr   in  : read port A / B index
//     rs_data, rt_data   out : read port A / B data
//     rs_busy, rt_busy   out : addressed register has a pending write
//     wr_en, wr_addr,
//     wr_data            in  : write-back strobe, destination, data
//     iss_en, iss_addr   in  : issue of an instruction with a destination
//     sb_ovf             out : sticky pending-counter overflow flag
//
//   Modport "master" is the decode / write-back side driving the bus.
// ----------------------------------------------------------------------------
interface regfile_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              rs_busy;
  logic              rt_busy;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              iss_en;
  logic [ADDR_W-1:0] iss_addr;
  logic              sb_ovf;

  modport master (
    output rs_addr, rt_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    input  rs_data, rt_data, rs_busy, rt_busy, sb_ovf
  );

  modport slave (
    input  rs_addr, rt_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    output rs_data, rt_data, rs_busy, rt_busy, sb_ovf
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// ----------------------------------------------------------------------------
// regfile_scoreboard
//   Architectural register file (2^ADDR_W x DATA_W, R0 hard-wired to zero)
//   with two combinational read ports, one synchronous write port and a
//   per-register saturating pending-write counter used by the hazard unit.
//
//   Parameters:
//     DATA_W : register width            (default 32)
//     ADDR_W : register index width      (default 5)
//     CNT_W  : pending counter width     (default 2)
//
//   Ports:
//     clk    : clock, all state updates on the rising edge
//     rst_n  : synchronous active-low reset (clears registers, counters, sb_ovf)
//     bus    : regfile_scoreboard_if.slave (read ports, write-back, issue,
//              busy flags and sticky sb_ovf)
//
//   Optional feature:
//     REGFILE_BYPASS_EN : when defined, a same-cycle write-back to a read
//                         address is forwarded to that port, and the port's
//                         busy flag reflects the count after the decrement.
// ----------------------------------------------------------------------------
module regfile_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_scoreboard_if.slave  bus
);

  localparam int              NREG    = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  logic [DATA_W-1:0] regs_r     [NREG];
  logic [CNT_W-1:0]  pend_r     [NREG];
  logic [CNT_W-1:0]  pend_nxt_s [NREG];
  logic              sb_ovf_r;
  logic              ovf_set_s;

  logic              wr_act_s;
  logic [NREG-1:0]   iss_hit_s;
  logic [NREG-1:0]   wr_hit_s;

  logic [DATA_W-1:0] rs_data_s;
  logic [DATA_W-1:0] rt_data_s;
  logic              rs_busy_s;
  logic              rt_busy_s;

  // Writes to R0 are discarded, so only a nonzero destination is an active write.
  assign wr_act_s  = bus.wr_en && (bus.wr_addr != {ADDR_W{1'b0}});

  // One-hot decode of the issue and write destinations.
  assign iss_hit_s = {{(NREG-1){1'b0}}, bus.iss_en} << bus.iss_addr;
  assign wr_hit_s  = {{(NREG-1){1'b0}}, bus.wr_en}  << bus.wr_addr;

  // Register storage: reset clears everything, otherwise commit the write-back.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (wr_act_s) begin
      regs_r[bus.wr_addr] <= bus.wr_data;
    end else begin
      regs_r <= regs_r;
    end
  end

  // Next pending count per register; issue and write to the same index cancel.
  always_comb begin
    pend_nxt_s = pend_r;
    ovf_set_s  = 1'b0;
    for (int i = 1; i < NREG; i++) begin
      case ({iss_hit_s[i], wr_hit_s[i]})
        2'b10: begin
          if (pend_r[i] == CNT_MAX) begin
            pend_nxt_s[i] = pend_r[i];
            ovf_set_s     = 1'b1;
          end else begin
            pend_nxt_s[i] = pend_r[i] + CNT_ONE;
          end
        end
        2'b01: begin
          // Decrement at zero is silently ignored.
          if (pend_r[i] != {CNT_W{1'b0}}) begin
            pend_nxt_s[i] = pend_r[i] - CNT_ONE;
          end else begin
            pend_nxt_s[i] = pend_r[i];
          end
        end
        default: begin
          pend_nxt_s[i] = pend_r[i];
        end
      endcase
    end
    // R0 never has a pending write.
    pend_nxt_s[0] = {CNT_W{1'b0}};
  end

  // Pending counters and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        pend_r[i] <= {CNT_W{1'b0}};
      end
      sb_ovf_r <= 1'b0;
    end else begin
      pend_r   <= pend_nxt_s;
      sb_ovf_r <= sb_ovf_r | ovf_set_s;
    end
  end

  // Read port A: registered state, optionally overridden by the write-back bypass.
  always_comb begin
    rs_data_s = {DATA_W{1'b0}};
    rs_busy_s = 1'b0;
    if (bus.rs_addr == {ADDR_W{1'b0}}) begin
      rs_data_s = {DATA_W{1'b0}};
      rs_busy_s = 1'b0;
`ifdef REGFILE_BYPASS_EN
    end else if (wr_act_s && (bus.wr_addr == bus.rs_addr)) begin
      // Busy as if the write-back decrement had already happened.
      rs_data_s = bus.wr_data;
      rs_busy_s = (pend_r[bus.rs_addr] > CNT_ONE);
`endif
    end else begin
      rs_data_s = regs_r[bus.rs_addr];
      rs_busy_s = (pend_r[bus.rs_addr] != {CNT_W{1'b0}});
    end
  end

  // Read port B: same structure as port A.
  always_comb begin
    rt_data_s = {DATA_W{1'b0}};
    rt_busy_s = 1'b0;
    if (bus.rt_addr == {ADDR_W{1'b0}}) begin
      rt_data_s = {DATA_W{1'b0}};
      rt_busy_s = 1'b0;
`ifdef REGFILE_BYPASS_EN
    end else if (wr_act_s && (bus.wr_addr == bus.rt_addr)) begin
      rt_data_s = bus.wr_data;
      rt_busy_s = (pend_r[bus.rt_addr] > CNT_ONE);
`endif
    end else begin
      rt_data_s = regs_r[bus.rt_addr];
      rt_busy_s = (pend_r[bus.rt_addr] != {CNT_W{1'b0}});
    end
  end

  assign bus.rs_data = rs_data_s;
  assign bus.rt_data = rt_data_s;
  assign bus.rs_busy = rs_busy_s;
  assign bus.rt_busy = rt_busy_s;
  assign bus.sb_ovf  = sb_ovf_r;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// ----------------------------------------------------------------------------
// tb_regfile_scoreboard
//   Directed self-checking bench for regfile_scoreboard. Each read step pushes
//   its expected port values to a scoreboard queue; the values are popped and
//   compared on the following falling edge. Expectations for the same-cycle
//   write cases follow REGFILE_BYPASS_EN.
// ----------------------------------------------------------------------------
module tb_regfile_scoreboard;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 2;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  regfile_scoreboard_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] rs_d;
    logic [31:0] rt_d;
    logic        rs_b;
    logic        rt_b;
    logic        ovf;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive read addresses and queue the expected outputs for this cycle.
  task automatic expect_rd(input string tag, input int rs, input int rt,
                           input logic [31:0] ers_d, input logic [31:0] ert_d,
                           input logic ers_b, input logic ert_b, input logic eovf);
    exp_t e;
    bus.rs_addr = ADDR_W'(rs);
    bus.rt_addr = ADDR_W'(rt);
    e.tag  = tag;
    e.rs_d = ers_d;
    e.rt_d = ert_d;
    e.rs_b = ers_b;
    e.rt_b = ert_b;
    e.ovf  = eovf;
    sb_q.push_back(e);
  endtask

  // Sample on the falling edge and compare against the oldest queued entry.
  task automatic check_out();
    exp_t e;
    @(negedge clk);
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_underflow: observed=empty expected=entry");
    end else begin
      e = sb_q.pop_front();
      chk32({e.tag, ".rs_data"}, bus.rs_data, e.rs_d);
      chk32({e.tag, ".rt_data"}, bus.rt_data, e.rt_d);
      chk1 ({e.tag, ".rs_busy"}, bus.rs_busy, e.rs_b);
      chk1 ({e.tag, ".rt_busy"}, bus.rt_busy, e.rt_b);
      chk1 ({e.tag, ".sb_ovf"},  bus.sb_ovf,  e.ovf);
    end
  endtask

  task automatic rd(input string tag, input int rs, input int rt,
                    input logic [31:0] ers_d, input logic [31:0] ert_d,
                    input logic ers_b, input logic ert_b, input logic eovf);
    expect_rd(tag, rs, rt, ers_d, ert_d, ers_b, ert_b, eovf);
    check_out();
  endtask

  initial begin
    bus.rs_addr  = 5'd0;
    bus.rt_addr  = 5'd0;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = 5'd0;
    bus.wr_data  = 32'd0;
    bus.iss_en   = 1'b0;
    bus.iss_addr = 5'd0;
    rst_n        = 1'b0;
    step();
    step();
    rst_n = 1'b1;

    // Reset state across every address.
    for (int i = 0; i < 32; i++) begin
      rd($sformatf("reset_a%0d", i), i, 31 - i, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
      step();
    end

    // Basic write to R5, then both ports read it.
    bus.wr_en = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 32'hDEADBEEF;
    step();
    bus.wr_en = 1'b0;
    rd("r5_read", 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
    step();

    // Write to R0 is discarded, never bypassed.
    bus.wr_en = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 32'hFFFFFFFF;
    rd("r0_wr_cycle", 0, 5, 32'd0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
    step();
    bus.wr_en = 1'b0;
    rd("r0_after", 0, 5, 32'd0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
    step();

    // R7 pending counter: two issues, then writes.
    bus.iss_en = 1'b1; bus.iss_addr = 5'd7;
    rd("r7_iss_same_cycle", 7, 0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    step();
    bus.iss_en = 1'b0;
    rd("r7_p1", 7, 0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    step();
    bus.iss_en = 1'b1;
    step();
    bus.iss_en = 1'b0;
    rd("r7_p2", 7, 7, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
    step();
    bus.wr_en = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 32'h00000077;
    rd("r7_wr1_same", 7, 0, BYP ? 32'h00000077 : 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    step();
    bus.wr_en = 1'b0;
    rd("r7_p1_after_wr", 7, 0, 32'h00000077, 32'd0, 1'b1, 1'b0, 1'b0);
    step();
    bus.wr_en = 1'b1; bus.wr_data = 32'h00000078;
    step();
    bus.wr_en = 1'b0;
    rd("r7_p0", 7, 0, 32'h00000078, 32'd0, 1'b0, 1'b0, 1'b0);
    step();

    // Issue and write to R7 in the same cycle leave P unchanged.
    bus.iss_en = 1'b1; bus.iss_addr = 5'd7;
    step();
    bus.iss_en = 1'b1; bus.wr_en = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 32'h00000079;
    rd("r7_both_same", 7, 0, BYP ? 32'h00000079 : 32'h00000078, 32'd0, BYP ? 1'b0 : 1'b1, 1'b0, 1'b0);
    step();
    bus.iss_en = 1'b0; bus.wr_en = 1'b0;
    rd("r7_both_after", 7, 0, 32'h00000079, 32'd0, 1'b1, 1'b0, 1'b0);
    step();
    bus.wr_en = 1'b1; bus.wr_data = 32'h0000007A;
    step();
    bus.wr_en = 1'b0;
    rd("r7_both_clear", 7, 0, 32'h0000007A, 32'd0, 1'b0, 1'b0, 1'b0);
    step();

    // R9 saturation: five issues, counter stops at 3, overflow from the fourth.
    for (int k = 1; k <= 5; k++) begin
      bus.iss_en = 1'b1; bus.iss_addr = 5'd9;
      step();
      bus.iss_en = 1'b0;
      rd($sformatf("r9_iss%0d", k), 9, 9, 32'd0, 32'd0, 1'b1, 1'b1, (k >= 4) ? 1'b1 : 1'b0);
      step();
    end
    for (int k = 1; k <= 4; k++) begin
      bus.wr_en = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 32'(k);
      step();
      bus.wr_en = 1'b0;
      rd($sformatf("r9_wr%0d", k), 9, 0, 32'(k), 32'd0, (k < 3) ? 1'b1 : 1'b0, 1'b0, 1'b1);
      step();
    end

    // Same-cycle write to R3 with P[3]=1.
    bus.iss_en = 1'b1; bus.iss_addr = 5'd3;
    step();
    bus.iss_en = 1'b0;
    bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 32'h12345678;
    rd("r3_same", 3, 5, BYP ? 32'h12345678 : 32'd0, 32'hDEADBEEF, BYP ? 1'b0 : 1'b1, 1'b0, 1'b1);
    step();
    bus.wr_en = 1'b0;
    rd("r3_next", 3, 5, 32'h12345678, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1);
    step();

    // Reset coincident with a write and an issue to R4: reset wins.
    rst_n = 1'b0;
    bus.wr_en = 1'b1; bus.wr_addr = 5'd4; bus.wr_data = 32'hAAAA5555;
    bus.iss_en = 1'b1; bus.iss_addr = 5'd4;
    step();
    rst_n = 1'b1;
    bus.wr_en = 1'b0; bus.iss_en = 1'b0;
    rd("rst_coinc_r4", 4, 5, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    step();
    rd("rst_coinc_r9r3", 9, 3, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    step();

    checks++;
    assert (sb_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: observed=%0d expected=0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Architectural register file for the 32-bit pipelined MIPS core: 32 × 32-bit general registers with two combinational read ports and one synchronous write port, backed by the per-register storage cells. A per-register pending-write counter tracks in-flight destinations so the decode-stage hazard unit can stall on a pending source. The block sits between decode (reads, issue) and write-back (writes).

## Interface
- `DATA_W`, default 32: register width.
- `ADDR_W`, default 5: register index width (2^ADDR_W registers).
- `CNT_W`, default 2: width of the per-register pending counter.

- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: reset, synchronous and active-low.
- `rs_addr` input, ADDR_W bits: read port A index.
- `rt_addr` input, ADDR_W bits: read port B index.
- `rs_data` output, DATA_W bits: read port A data.
- `rt_data` output, DATA_W bits: read port B data.
- `rs_busy` output, 1 bit: register `rs_addr` has a pending write.
- `rt_busy` output, 1 bit: register `rt_addr` has a pending write.
- `wr_en` input, 1 bit: write-back strobe.
- `wr_addr` input, ADDR_W bits: write destination.
- `wr_data` input, DATA_W bits: write data.
- `iss_en` input, 1 bit: instruction issued with a destination register.
- `iss_addr` input, ADDR_W bits: destination marked pending.
- `sb_ovf` output, 1 bit: sticky; an issue arrived at a saturated counter.

## Operation
- Reads are combinational: `rs_data = R[rs_addr]`, `rt_data = R[rt_addr]`. R0 always reads 0.
- Write: when `wr_en`=1 and `wr_addr`≠0, `R[wr_addr] <= wr_data` at the edge. Writes to R0 are discarded.
- Pending counter `P[i]`, CNT_W bits, per register:
  - `iss_en` to i only: increment, saturating at 2^CNT_W−1. An issue at saturation leaves the count unchanged and sets `sb_ovf`.
  - `wr_en` to i only: decrement. A decrement at 0 leaves the count at 0 (no error).
  - Both to the same i in the same cycle: count unchanged.
  - Index 0: the counter never changes; `P[0]` is always 0.
- `rs_busy = (P[rs_addr]≠0)` and `rt_busy = (P[rt_addr]≠0)`, subject to bypass (see Configuration).
- `sb_ovf` is cleared only by reset.

## Timing
- Synchronous reset (`rst_n`=0 at an edge) clears all R[i], all P[i] and `sb_ovf`.
- After reset: `rs_data`=`rt_data`=0, `rs_busy`=`rt_busy`=0, `sb_ovf`=0.
- Reset asserted in the same cycle as `wr_en` or `iss_en`: reset wins and the write or issue is lost.
- Write latency is 1 cycle. Without bypass, the new value is visible on the read ports in the cycle after `wr_en`.
- Issue latency is 1 cycle. Busy asserts in the cycle after `iss_en`.
- Read-port outputs depend only on addresses and current state. The only same-cycle input-to-output path is the bypass path.

## Configuration
- `REGFILE_BYPASS_EN`, when defined (write-through bypass):
  - If `wr_en`=1, `wr_addr`≠0 and a read address equals `wr_addr`, that port returns `wr_data` in the same cycle.
  - That port's busy is computed as if the decrement had already occurred: busy = `(P−1)≠0` when P>0.
- When undefined: reads and busy reflect only the registered state. Same-cycle write-back is visible one cycle later.

## Test plan
- Reset, then read all 32 addresses: every `*_data`=0, every `*_busy`=0, `sb_ovf`=0.
- Write 0xDEADBEEF to R5, then read with `rs_addr`=`rt_addr`=5 next cycle: both ports read 0xDEADBEEF. Write 0xFFFFFFFF to R0: R0 still reads 0.
- Issue R7, then issue R7 again, then write R7 once: `rs_busy` reads 1 after the first issue (P=1), 1 after the second (P=2), and still 1 after the write (P=1). A second write clears busy. Issue and write R7 in the same cycle: P is unchanged.
- Issue R9 four times with `CNT_W`=2: P saturates at 3 and `sb_ovf`=1 from the fourth issue onward. `sb_ovf` stays 1 until reset.
- Same-cycle write of 0x12345678 to R3 with `rs_addr`=3, P[3]=1:
  - With `REGFILE_BYPASS_EN`: `rs_data`=0x12345678 and `rs_busy`=0 in that cycle.
  - Without it: the old value and `rs_busy`=1, then the new value and busy=0 next cycle.
- `rst_n`=0 held for one cycle, coincident with a write to R4 and an issue to R4: R4 reads 0, busy=0, and `sb_ovf`=0 afterwards.
